fifo_buffer_v2: RTL and testbench

Parametrised synchronous FIFO that replaces the fixed 8x8 buffer throughout the design.
- Generalised width, depth and programmable almost-full/almost-empty thresholds.
- Adds concurrent read+write in one cycle, selectable standard or first-word-fall-through (FWFT) read mode, occupancy output, synchronous flush, and sticky overflow/underflow error flags.
- Sits between sys_clk-domain producers and consumers, e.g. UART/display data paths.

---
 rtl/fifo_buffer_v2_if.sv | 37 +++
 rtl/fifo_buffer_v2.sv | 127 ++++++++++++
 tb/tb_fifo_buffer_v2.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fifo_buffer_v2_if.sv
// Handshake/data bundle between a fifo_buffer_v2 and its producer/consumer.
// master: drives control and write data; slave: the FIFO itself.
// Ports: EN, clr, wr, data_in, rd, err_clr -> FIFO; data_o, rd_valid, status flags, count, error flags <- FIFO.
interface fifo_buffer_v2_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             EN;
    logic             clr;
    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             rd;
    logic             err_clr;
    logic [WIDTH-1:0] data_o;
    logic             rd_valid;
    logic             EMPTY;
    logic             FULL;
    logic             ALMOST_EMPTY;
    logic             ALMOST_FULL;
    logic [CW-1:0]    count;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output EN, clr, wr, data_in, rd, err_clr,
        input  data_o, rd_valid, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               count, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  EN, clr, wr, data_in, rd, err_clr,
        output data_o, rd_valid, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL,
               count, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/fifo_buffer_v2.sv
// Parametrised synchronous FIFO with flush, occupancy, thresholds and sticky errors.
// Latency: standard mode data_o/rd_valid 1 cycle after rd; FWFT mode head word visible 1 cycle after its write.
// Backpressure: writes rejected when FULL (unless paired with an accepted read), reads rejected when EMPTY; rejections set sticky flags.
// Ports: sys_clk, rst_n (synchronous, active-low), bus (fifo_buffer_v2_if.slave) carrying all control, data and status.
module fifo_buffer_v2 #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    fifo_buffer_v2_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             overflow;
    logic             underflow;

    logic en;
    logic act;
    logic empty;
    logic full;
    logic rd_acc;
    logic wr_acc;
    logic ovf_set;
    logic udf_set;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign en    = bus.EN;
    // Read/write are only considered when enabled and not flushing.
    assign act   = en & ~bus.clr;
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    assign rd_acc  = act & bus.rd & ~empty;
    // A write into a full FIFO is fine when a read frees a slot this cycle.
    assign wr_acc  = act & bus.wr & (~full | rd_acc);
    assign ovf_set = act & bus.wr & ~wr_acc;
    assign udf_set = act & bus.rd & ~rd_acc;

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge sys_clk) begin
        if (wr_acc) begin
            mem[wptr] <= bus.data_in;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rptr      <= '0;
            wptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (en) begin
            if (bus.clr) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (rd_acc) rptr <= ptr_inc(rptr);
                if (wr_acc) wptr <= ptr_inc(wptr);
                count <= count_next;
            end
            // A new error in the same cycle as err_clr still sets the flag.
            overflow  <= ovf_set | (overflow  & ~bus.err_clr);
            underflow <= udf_set | (underflow & ~bus.err_clr);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_o   = mem[rptr];
            assign bus.rd_valid = ~empty;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             vld_q;

            // rd_acc already excludes clr, so a flush drops rd_valid and holds data_o.
            always_ff @(posedge sys_clk) begin
                if (!rst_n) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else if (en) begin
                    if (rd_acc) begin
                        dout_q <= mem[rptr];
                        vld_q  <= 1'b1;
                    end else begin
                        vld_q  <= 1'b0;
                    end
                end
            end

            assign bus.data_o   = dout_q;
            assign bus.rd_valid = vld_q;
        end
    endgenerate

    assign bus.count        = count;
    assign bus.EMPTY        = empty;
    assign bus.FULL         = full;
    assign bus.ALMOST_EMPTY = (int'(count) <= AE_LEVEL);
    assign bus.ALMOST_FULL  = (int'(count) >= AF_LEVEL);
    assign bus.OVERFLOW     = overflow;
    assign bus.UNDERFLOW    = underflow;
endmodule

// File: tb/tb_fifo_buffer_v2.sv
// Self-checking bench for fifo_buffer_v2 (DEPTH=8, WIDTH=8, AF=6, AE=1) in standard and FWFT modes.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercised through full/empty accept rules and sticky error flags.
module tb_fifo_buffer_v2;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    fifo_buffer_v2_if #(.WIDTH(8), .DEPTH(8)) bs ();
    fifo_buffer_v2_if #(.WIDTH(8), .DEPTH(8)) bf ();

    fifo_buffer_v2 #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) dut_std (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bs.slave)
    );

    fifo_buffer_v2 #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1)) dut_fwft (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bf.slave)
    );

    typedef struct {
        logic       en, clr, wr, rd, ec;
        logic [7:0] din;
        int         cnt;
        logic       ovf, udf, rv;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    function automatic void add(input logic en, clr, wr, rd, ec, input logic [7:0] din,
                                input int cnt, input logic ovf, udf, rv, input logic [7:0] dout);
        vec_t v;
        v.en = en; v.clr = clr; v.wr = wr; v.rd = rd; v.ec = ec; v.din = din;
        v.cnt = cnt; v.ovf = ovf; v.udf = udf; v.rv = rv; v.dout = dout;
        vecs.push_back(v);
    endfunction

    task automatic drive_std(input logic en, clr, wr, rd, ec, input logic [7:0] din);
        bs.EN = en; bs.clr = clr; bs.wr = wr; bs.rd = rd; bs.err_clr = ec; bs.data_in = din;
    endtask

    task automatic drive_fwft(input logic en, clr, wr, rd, ec, input logic [7:0] din);
        bf.EN = en; bf.clr = clr; bf.wr = wr; bf.rd = rd; bf.err_clr = ec; bf.data_in = din;
    endtask

    // Flags for this configuration: FULL at 8, ALMOST_FULL at >=6, ALMOST_EMPTY at <=1.
    task automatic chk_std(input string nm, input int idx, input int cnt,
                           input logic ovf, udf, rv, input logic [7:0] dout);
        chk({nm, ".count"}, idx, 32'(bs.count), 32'(cnt));
        chk({nm, ".empty"}, idx, 32'(bs.EMPTY), 32'(cnt == 0));
        chk({nm, ".full"},  idx, 32'(bs.FULL),  32'(cnt == 8));
        chk({nm, ".ae"},    idx, 32'(bs.ALMOST_EMPTY), 32'(cnt <= 1));
        chk({nm, ".af"},    idx, 32'(bs.ALMOST_FULL),  32'(cnt >= 6));
        chk({nm, ".ovf"},   idx, 32'(bs.OVERFLOW),  32'(ovf));
        chk({nm, ".udf"},   idx, 32'(bs.UNDERFLOW), 32'(udf));
        chk({nm, ".rv"},    idx, 32'(bs.rd_valid),  32'(rv));
        chk({nm, ".dout"},  idx, 32'(bs.data_o),    32'(dout));
    endtask

    initial begin
        // ---------------- directed vector table (standard mode) ----------------
        for (int i = 1; i <= 8; i++) add(1, 0, 1, 0, 0, 8'(i), i, 0, 0, 0, 8'h00);
        add(1, 0, 1, 0, 0, 8'h09, 8, 1, 0, 0, 8'h00);      // 9th write rejected
        add(1, 0, 0, 0, 1, 8'h00, 8, 0, 0, 0, 8'h00);      // err_clr
        add(1, 0, 1, 1, 0, 8'hAA, 8, 0, 0, 1, 8'h01);      // full rd+wr
        for (int i = 0; i < 8; i++)
            add(1, 0, 0, 1, 0, 8'h00, 7 - i, 0, 0, 1, (i < 7) ? 8'(i + 2) : 8'hAA);
        add(1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 8'hAA);      // read on empty
        add(1, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'hAA);
        add(1, 0, 1, 1, 0, 8'h33, 1, 0, 1, 0, 8'hAA);      // empty rd+wr: write only
        add(1, 0, 0, 0, 1, 8'h00, 1, 0, 0, 0, 8'hAA);
        for (int i = 0; i < 4; i++) add(1, 0, 1, 0, 0, 8'(8'h34 + i), 2 + i, 0, 0, 0, 8'hAA);
        add(1, 0, 0, 1, 0, 8'h00, 4, 0, 0, 1, 8'h33);
        add(0, 0, 1, 1, 0, 8'h99, 4, 0, 0, 1, 8'h33);      // EN=0: everything holds
        add(0, 1, 0, 1, 1, 8'h99, 4, 0, 0, 1, 8'h33);
        add(0, 0, 1, 0, 0, 8'h99, 4, 0, 0, 1, 8'h33);
        add(1, 0, 1, 0, 0, 8'h38, 5, 0, 0, 0, 8'h33);
        add(1, 1, 1, 1, 0, 8'h77, 0, 0, 0, 0, 8'h33);      // flush at count 5

        drive_std(0, 0, 0, 0, 0, 8'h00);
        drive_fwft(0, 0, 0, 0, 0, 8'h00);
        rst_n = 1'b0;
        tick();
        tick();
        chk_std("reset", 0, 0, 0, 0, 0, 8'h00);
        chk("reset.fwft_rv",    0, 32'(bf.rd_valid), 32'd0);
        chk("reset.fwft_empty", 0, 32'(bf.EMPTY),    32'd1);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive_std(vecs[i].en, vecs[i].clr, vecs[i].wr, vecs[i].rd, vecs[i].ec, vecs[i].din);
            tick();
            chk_std("vec", i, vecs[i].cnt, vecs[i].ovf, vecs[i].udf, vecs[i].rv, vecs[i].dout);
        end

        // ---------------- reset while disabled ----------------
        drive_std(1, 0, 0, 1, 0, 8'h00); tick();            // underflow
        drive_std(1, 0, 1, 0, 0, 8'h44); tick();
        drive_std(1, 0, 1, 0, 0, 8'h45); tick();
        drive_std(1, 0, 0, 1, 0, 8'h00); tick();
        chk_std("pre_rst", 0, 1, 0, 1, 1, 8'h44);
        drive_std(0, 0, 1, 1, 0, 8'h00);
        rst_n = 1'b0;
        tick();
        chk_std("rst_en0", 0, 0, 0, 0, 0, 8'h00);
        rst_n = 1'b1;

        // ---------------- wrap-around streaming at count 4 ----------------
        for (int k = 0; k < 4; k++) begin
            drive_std(1, 0, 1, 0, 0, 8'(k));
            tick();
        end
        for (int k = 0; k < 100; k++) begin
            drive_std(1, 0, 1, 1, 0, 8'(k + 4));
            tick();
            chk("wrap.count", k, 32'(bs.count),    32'd4);
            chk("wrap.dout",  k, 32'(bs.data_o),   32'(k));
            chk("wrap.rv",    k, 32'(bs.rd_valid), 32'd1);
            chk("wrap.err",   k, 32'({bs.OVERFLOW, bs.UNDERFLOW}), 32'd0);
        end
        drive_std(0, 0, 0, 0, 0, 8'h00);

        // ---------------- FWFT mode ----------------
        drive_fwft(1, 0, 1, 0, 0, 8'h5A); tick();
        chk("fwft.dout1", 0, 32'(bf.data_o),   32'h5A);
        chk("fwft.rv1",   0, 32'(bf.rd_valid), 32'd1);
        drive_fwft(1, 0, 0, 1, 0, 8'h00); tick();
        chk("fwft.empty", 0, 32'(bf.EMPTY),    32'd1);
        chk("fwft.rv0",   0, 32'(bf.rd_valid), 32'd0);
        drive_fwft(1, 0, 1, 0, 0, 8'h5B); tick();
        chk("fwft.dout2", 0, 32'(bf.data_o),   32'h5B);
        drive_fwft(1, 0, 1, 0, 0, 8'h5C); tick();
        chk("fwft.dout3", 0, 32'(bf.data_o),   32'h5B);
        drive_fwft(1, 0, 0, 1, 0, 8'h00); tick();
        chk("fwft.dout4", 0, 32'(bf.data_o),   32'h5C);
        chk("fwft.count", 0, 32'(bf.count),    32'd1);
        chk("fwft.rv2",   0, 32'(bf.rd_valid), 32'd1);
        drive_fwft(0, 0, 0, 0, 0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
